dirty_range_dump_streamer: RTL and testbench

//  Downstream consumer of memory_range_tracker: on a start pulse (CPU halted), streams the

---
 rtl/debug_pkg.sv | 17 +
 rtl/dirty_range_dump_streamer.sv | 118 +++++++++++
 tb/tb_dirty_range_dump_streamer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared debug-path types: dump FSM states and word/alignment constants.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_MIN,
        SEND_MAX,
        READ,
        WAIT_MEM,
        SEND_WORD,
        DONE
    } dump_state_e;

    localparam int          WORD_BYTES      = 4;
    localparam logic [31:0] ADDR_ALIGN_MASK = ~32'h3;

endpackage

// File: rtl/dirty_range_dump_streamer.sv
// Streams a latched dirty memory window (2-word min/max header, then aligned words) to the debug link.
// Latency: 1 word per 3 cycles at full rate; outputs decode registered state only, stalls hold data.
module dirty_range_dump_streamer
    import debug_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] min_addr_i,
    input  logic [ADDR_WIDTH-1:0] max_addr_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  tx_valid_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(ADDR_ALIGN_MASK);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(WORD_BYTES);

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] min_q, min_d;
    logic [ADDR_WIDTH-1:0] max_q, max_d;
    logic [ADDR_WIDTH-1:0] hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            hi_q    <= '0;
            cur_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            hi_q    <= hi_d;
            cur_q   <= cur_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        min_d         = min_q;
        max_d         = max_q;
        hi_d          = hi_q;
        cur_d         = cur_q;
        hold_d        = hold_q;
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;
        tx_valid_o    = 1'b0;
        tx_data_o     = '0;
        done_o        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    min_d   = min_addr_i;
                    max_d   = max_addr_i;
                    cur_d   = min_addr_i & ALIGN_MASK;
                    hi_d    = max_addr_i & ALIGN_MASK;
                    state_d = SEND_MIN;
                end
            end
            SEND_MIN: begin
                tx_valid_o = 1'b1;
                tx_data_o  = DATA_WIDTH'(min_q);
                if (tx_ready_i) state_d = SEND_MAX;
            end
            SEND_MAX: begin
                tx_valid_o = 1'b1;
                tx_data_o  = DATA_WIDTH'(max_q);
                // A flushed tracker reports min > max: header only, no reads.
                if (tx_ready_i) state_d = (min_q > max_q) ? DONE : READ;
            end
            READ: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = cur_q;
                state_d       = WAIT_MEM;
            end
            WAIT_MEM: begin
                hold_d  = mem_rd_data_i;
                state_d = SEND_WORD;
            end
            SEND_WORD: begin
                tx_valid_o = 1'b1;
                tx_data_o  = hold_q;
                // Compare against hi rather than stepping past it, so the top word cannot wrap.
                if (tx_ready_i) begin
                    if (cur_q == hi_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_q + ADDR_STEP;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_dirty_range_dump_streamer.sv
// Directed bench for dirty_range_dump_streamer with a registered read-latency memory model.
module tb_dirty_range_dump_streamer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] min_addr_i;
    logic [31:0] max_addr_i;
    logic        mem_rd_en_o;
    logic [31:0] mem_rd_addr_o;
    logic [31:0] mem_rd_data_i;
    logic        tx_valid_o;
    logic [31:0] tx_data_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] words_q[$];
    logic [31:0] reads_q[$];
    int          busy_cnt;
    int          done_cnt;
    int          stall_err;
    int          stall_seen;
    bit          done_with_busy;

    dirty_range_dump_streamer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .min_addr_i    (min_addr_i),
        .max_addr_i    (max_addr_i),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_data_i (mem_rd_data_i),
        .tx_valid_o    (tx_valid_o),
        .tx_data_o     (tx_data_o),
        .tx_ready_i    (tx_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns addr ^ 5A5A_0000 exactly one cycle after a read strobe, junk otherwise.
    always @(posedge clk)
        mem_rd_data_i <= mem_rd_en_o ? (mem_rd_addr_o ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;

    // Runs one dump and records the observed stream; inj_cyc >= 0 pulses a second start mid-dump.
    task automatic run_dump(input logic [31:0] mn, input logic [31:0] mx, input bit rnd,
                            input int inj_cyc, output bit timed_out);
        bit          prev_stall;
        logic [31:0] prev_data;
        words_q.delete();
        reads_q.delete();
        busy_cnt = 0; done_cnt = 0; stall_err = 0; stall_seen = 0;
        done_with_busy = 1'b0; prev_stall = 1'b0; prev_data = '0;
        timed_out = 1'b1;
        @(posedge clk) #1;
        min_addr_i = mn; max_addr_i = mx; start_i = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (tx_valid_o && tx_ready_i) words_q.push_back(tx_data_o);
            if (mem_rd_en_o) reads_q.push_back(mem_rd_addr_o);
            if (busy_o) busy_cnt++;
            if (prev_stall) begin
                stall_seen++;
                if (!tx_valid_o || tx_data_o !== prev_data) stall_err++;
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
            if (done_o) begin
                done_cnt++;
                done_with_busy = busy_o;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk) #1;
            start_i = (cyc == inj_cyc);
            if (cyc == inj_cyc) begin
                min_addr_i = 32'h0;
                max_addr_i = 32'h4;
            end
            if (rnd) tx_ready_i = 1'($urandom_range(0, 1));
        end
        @(posedge clk) #1;
        start_i    = 1'b0;
        tx_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({tx_valid_o, mem_rd_en_o, busy_o, done_o} !== 4'b0 || tx_data_o !== 32'h0 || mem_rd_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_in: valid=%b rd=%b busy=%b done=%b data=%h addr=%h, required all 0",
                     tx_valid_o, mem_rd_en_o, busy_o, done_o, tx_data_o, mem_rd_addr_o);
        end
        @(posedge clk) #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_valid_o, mem_rd_en_o, busy_o, done_o} !== 4'b0 || tx_data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b rd=%b busy=%b done=%b data=%h, required all 0",
                     tx_valid_o, mem_rd_en_o, busy_o, done_o, tx_data_o);
        end
    endtask

    task automatic test_empty();
        bit to;
        logic [31:0] exp[$] = '{32'hFFFF_FFFF, 32'h0000_0000};
        run_dump(32'hFFFF_FFFF, 32'h0, 1'b0, -1, to);
        checks++;
        if (to || words_q.size() != 2 || words_q[0] !== exp[0] || words_q[1] !== exp[1]) begin
            failures++;
            $display("FAIL empty_stream: timeout=%b n=%0d w0=%h w1=%h, required n=2 %h %h",
                     to, words_q.size(), words_q[0], words_q[1], exp[0], exp[1]);
        end
        checks++;
        if (reads_q.size() != 0) begin
            failures++;
            $display("FAIL empty_reads: reads=%0d, required 0", reads_q.size());
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL empty_done: done=%0d, required 1", done_cnt);
        end
    endtask

    task automatic test_single();
        bit to;
        logic [31:0] exp[$] = '{32'h0000_1002, 32'h0000_1002, 32'h5A5A_1000};
        run_dump(32'h1002, 32'h1002, 1'b0, -1, to);
        checks++;
        if (to || words_q.size() != 3) begin
            failures++;
            $display("FAIL single_count: timeout=%b n=%0d, required 3", to, words_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (words_q[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL single_word[%0d]: got %h, required %h", i, words_q[i], exp[i]);
                end
            end
        end
        checks++;
        if (reads_q.size() != 1 || reads_q[0] !== 32'h1000) begin
            failures++;
            $display("FAIL single_reads: n=%0d a0=%h, required 1 read at 00001000", reads_q.size(), reads_q[0]);
        end
    endtask

    task automatic test_multi();
        bit to;
        logic [31:0] exp[$]  = '{32'h100, 32'h10C, 32'h5A5A_0100, 32'h5A5A_0104, 32'h5A5A_0108, 32'h5A5A_010C};
        logic [31:0] expr[$] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        run_dump(32'h100, 32'h10C, 1'b0, -1, to);
        checks++;
        if (to || words_q.size() != 6 || reads_q.size() != 4) begin
            failures++;
            $display("FAIL multi_count: timeout=%b words=%0d reads=%0d, required 6 and 4", to, words_q.size(), reads_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (words_q[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL multi_word[%0d]: got %h, required %h", i, words_q[i], exp[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (reads_q[i] !== expr[i]) begin
                    failures++;
                    $display("FAIL multi_read[%0d]: got %h, required %h", i, reads_q[i], expr[i]);
                end
            end
        end
        // Full rate: 2 header cycles + 3 cycles per word, busy low in the done cycle.
        checks++;
        if (busy_cnt != 14 || done_with_busy) begin
            failures++;
            $display("FAIL multi_timing: busy_cycles=%0d busy_at_done=%b, required 14 and 0", busy_cnt, done_with_busy);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [31:0] exp[$] = '{32'h203, 32'h20A, 32'h5A5A_0200, 32'h5A5A_0204, 32'h5A5A_0208};
        run_dump(32'h203, 32'h20A, 1'b1, -1, to);
        checks++;
        if (to || words_q.size() != 5) begin
            failures++;
            $display("FAIL bp_count: timeout=%b n=%0d, required 5", to, words_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (words_q[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL bp_word[%0d]: got %h, required %h", i, words_q[i], exp[i]);
                end
            end
        end
        checks++;
        if (stall_err != 0 || stall_seen == 0) begin
            failures++;
            $display("FAIL bp_stable: unstable_stalls=%0d stalls=%0d, required 0 and >0", stall_err, stall_seen);
        end
    endtask

    task automatic test_top_boundary();
        bit to;
        run_dump(32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0, -1, to);
        checks++;
        if (to || reads_q.size() != 2 || reads_q[0] !== 32'hFFFF_FFF8 || reads_q[1] !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL top_reads: timeout=%b n=%0d a0=%h a1=%h, required FFFFFFF8 FFFFFFFC",
                     to, reads_q.size(), reads_q[0], reads_q[1]);
        end
        checks++;
        if (words_q.size() != 4 || words_q[2] !== 32'hA5A5_FFF8 || words_q[3] !== 32'hA5A5_FFFC || words_q[1] !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL top_words: n=%0d w1=%h w2=%h w3=%h, required 4 FFFFFFFF A5A5FFF8 A5A5FFFC",
                     words_q.size(), words_q[1], words_q[2], words_q[3]);
        end
    endtask

    task automatic test_restart_ignored();
        bit to;
        run_dump(32'h300, 32'h31C, 1'b0, 6, to);
        checks++;
        if (to || words_q.size() != 10 || words_q[0] !== 32'h300 || words_q[1] !== 32'h31C) begin
            failures++;
            $display("FAIL restart_hdr: timeout=%b n=%0d w0=%h w1=%h, required 10 00000300 0000031C",
                     to, words_q.size(), words_q[0], words_q[1]);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (words_q[i+2] !== (32'h5A5A_0300 + 32'(4*i))) begin
                    failures++;
                    $display("FAIL restart_word[%0d]: got %h, required %h", i, words_q[i+2], 32'h5A5A_0300 + 32'(4*i));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL restart_queued: busy=%b, required 0", busy_o);
        end
    endtask

    task automatic test_reset_abort();
        bit to;
        int done_seen = 0;
        @(posedge clk) #1;
        min_addr_i = 32'h400; max_addr_i = 32'h40C; start_i = 1'b1;
        @(posedge clk) #1 start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_valid_o, mem_rd_en_o, busy_o, done_o} !== 4'b0 || tx_data_o !== 32'h0 || mem_rd_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL abort_outputs: valid=%b rd=%b busy=%b done=%b data=%h addr=%h, required all 0",
                     tx_valid_o, mem_rd_en_o, busy_o, done_o, tx_data_o, mem_rd_addr_o);
        end
        repeat (3) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        @(posedge clk) #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL abort_done: done pulses=%0d, required 0", done_seen);
        end
        run_dump(32'h500, 32'h504, 1'b0, -1, to);
        checks++;
        if (to || words_q.size() != 4 || words_q[2] !== 32'h5A5A_0500 || words_q[3] !== 32'h5A5A_0504 || done_cnt != 1) begin
            failures++;
            $display("FAIL abort_recover: timeout=%b n=%0d w2=%h w3=%h done=%0d, required 4 5A5A0500 5A5A0504 1",
                     to, words_q.size(), words_q[2], words_q[3], done_cnt);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        min_addr_i = '0;
        max_addr_i = '0;
        tx_ready_i = 1'b1;
        test_reset();
        test_empty();
        test_single();
        test_multi();
        test_backpressure();
        test_top_boundary();
        test_restart_ignored();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
